uwasic_onboarding_zachary_grosman: RTL and testbench



---
 rtl/uwasic_onboarding_pkg.sv | 31 +++
 rtl/spi_peripheral.sv | 146 ++++++++++++++
 rtl/uwasic_onboarding_zachary_grosman.sv | 80 ++++++++
 tb/tb_uwasic_onboarding_zachary_grosman.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uwasic_onboarding_pkg.sv
// Shared constants for the SPI-programmed PWM output block.
// Optional feature macro: PWM_POLARITY_EN (adds polarity register 0x05).
package uwasic_onboarding_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned OUT_W      = 16;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
`ifdef PWM_POLARITY_EN
  localparam logic [ADDR_W-1:0] ADDR_POLARITY  = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_MAX       = ADDR_POLARITY;
`else
  localparam logic [ADDR_W-1:0] ADDR_MAX       = ADDR_DUTY;
`endif

  // A frame is accepted only when exactly FRAME_BITS bits were captured,
  // the MSB marks a write and the address is in range.
  function automatic logic frame_is_valid(input logic [FRAME_BITS-1:0] frame,
                                          input logic [CNT_W-1:0]      count);
    return (count == CNT_W'(FRAME_BITS)) && frame[FRAME_BITS-1] &&
           (frame[FRAME_BITS-2 -: ADDR_W] <= ADDR_MAX);
  endfunction

endpackage

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only slave sampled in the system clock domain, plus the
// control register bank. Macro PWM_POLARITY_EN adds the polarity register.
module spi_peripheral
  import uwasic_onboarding_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              copi_i,
  input  logic              ncs_i,
  output logic [OUT_W-1:0]  en_out_o,
  output logic [OUT_W-1:0]  en_pwm_o,
  output logic [DATA_W-1:0] duty_o,
  output logic              pol_inv_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   commit_q, commit_d;

  logic [OUT_W-1:0]       en_out_q, en_out_d;
  logic [OUT_W-1:0]       en_pwm_q, en_pwm_d;
  logic [DATA_W-1:0]      duty_q, duty_d;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;

  // nCS resets high so the idle bus does not look like a falling edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, sclk_i});
      copi_sync_q <= SYNC_STAGES'({copi_sync_q, copi_i});
      ncs_sync_q  <= SYNC_STAGES'({ncs_sync_q, ncs_i});
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  always_comb begin
    shift_d  = shift_q;
    count_d  = count_q;
    commit_d = 1'b0;
    if (ncs_fall) begin
      shift_d = '0;
      count_d = '0;
    end else if (!ncs_s && sclk_rise && (count_q != CNT_W'(FRAME_BITS))) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
      count_d = count_q + CNT_W'(1);
    end
    if (ncs_rise) begin
      commit_d = frame_is_valid(shift_q, count_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q  <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      count_q  <= count_d;
      commit_q <= commit_d;
    end
  end

  // The shift register holds still while nCS is high, so the frame is
  // still intact one clock after the commit decision.
  assign wr_addr = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign wr_data = shift_q[DATA_W-1:0];

  always_comb begin
    en_out_d = en_out_q;
    en_pwm_d = en_pwm_q;
    duty_d   = duty_q;
    if (commit_q) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: en_out_d[7:0]  = wr_data;
        ADDR_EN_OUT_HI: en_out_d[15:8] = wr_data;
        ADDR_EN_PWM_LO: en_pwm_d[7:0]  = wr_data;
        ADDR_EN_PWM_HI: en_pwm_d[15:8] = wr_data;
        ADDR_DUTY:      duty_d         = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q   <= '0;
    end else begin
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      duty_q   <= duty_d;
    end
  end

`ifdef PWM_POLARITY_EN
  logic pol_inv_q, pol_inv_d;

  always_comb begin
    pol_inv_d = pol_inv_q;
    if (commit_q && (wr_addr == ADDR_POLARITY)) begin
      pol_inv_d = wr_data[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pol_inv_q <= 1'b0;
    end else begin
      pol_inv_q <= pol_inv_d;
    end
  end

  assign pol_inv_o = pol_inv_q;
`else
  assign pol_inv_o = 1'b0;
`endif

  assign en_out_o = en_out_q;
  assign en_pwm_o = en_pwm_q;
  assign duty_o   = duty_q;

endmodule

// File: rtl/uwasic_onboarding_zachary_grosman.sv
// Tiny Tapeout top: SPI register file drives 16 outputs, optionally PWM'd.
// Optional feature macro: PWM_POLARITY_EN (inverts PWM on enabled outputs).
module uwasic_onboarding_zachary_grosman
  import uwasic_onboarding_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 13,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [OUT_W-1:0]  en_out, en_pwm;
  logic [DATA_W-1:0] duty;
  logic              pol_inv;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic              pre_wrap;
  logic              pwm, pwm_drive;
  logic [OUT_W-1:0]  out_q, out_d;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in};

  spi_peripheral #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_spi (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sclk_i   (ui_in[0]),
    .copi_i   (ui_in[1]),
    .ncs_i    (ui_in[2]),
    .en_out_o (en_out),
    .en_pwm_o (en_pwm),
    .duty_o   (duty),
    .pol_inv_o(pol_inv)
  );

  assign pre_wrap = (pre_q == PRE_W'(CLK_DIV - 1));

  always_comb begin
    pre_d     = pre_wrap ? '0 : pre_q + PRE_W'(1);
    pwm_cnt_d = pre_wrap ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // Duty is compared live against the free-running counter, so a new duty
  // value lands mid-period without restarting it.
  assign pwm       = (duty == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty);
  assign pwm_drive = pwm ^ pol_inv;

  always_comb begin
    out_d = en_out & ((en_pwm & {OUT_W{pwm_drive}}) | ~en_pwm);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = '1;

endmodule

// File: tb/tb_uwasic_onboarding_zachary_grosman.sv
// Directed bench: SPI frames drive a register model; expected outputs are
// queued on stimulus and popped when the DUT output has settled.
module tb_uwasic_onboarding_zachary_grosman;

  localparam int unsigned CLK_DIV = 13;
  localparam int          PERIOD  = 256 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign ui_in  = {5'b0, ncs, copi, sclk};
  assign uio_in = 8'h00;

  always #50 clk = ~clk;

  uwasic_onboarding_zachary_grosman #(
    .CLK_DIV    (CLK_DIV),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_en_out = '0, m_en_pwm = '0;
  logic [7:0]  m_duty = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_static();
    return (m_duty == 8'h00) || (m_duty == 8'hFF) || ((m_en_out & m_en_pwm) == 16'h0000);
  endfunction

  function automatic logic [15:0] model_out();
    logic pwm;
    pwm = (m_duty == 8'hFF);
    return m_en_out & ((m_en_pwm & {16{pwm}}) | ~m_en_pwm);
  endfunction

  task automatic model_reset();
    m_en_out = '0;
    m_en_pwm = '0;
    m_duty   = '0;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Sends n bits MSB first, updates the model, then checks the settled output.
  task automatic spi_send(input logic [31:0] bits, input int n, input string tag);
    logic [15:0] frame;
    exp_t        e;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(bits, n);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    if (n >= 16) begin
      frame = bits[n-1 -: 16];
      if (frame[15] && (frame[14:8] <= 7'h04)) begin
        case (frame[14:8])
          7'h00: m_en_out[7:0]  = frame[7:0];
          7'h01: m_en_out[15:8] = frame[7:0];
          7'h02: m_en_pwm[7:0]  = frame[7:0];
          7'h03: m_en_pwm[15:8] = frame[7:0];
          default: m_duty       = frame[7:0];
        endcase
      end
    end
    if (model_static()) sb_q.push_back('{tag, model_out()});
    repeat (12) @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, {uio_out, uo_out}, {16'h0, e.value});
    end
  endtask

  task automatic hold_check(input logic level, input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (uo_out[0] !== level) bad = 1'b1;
    end
    check_val(tag, bad, 1'b0);
  endtask

  initial begin
    logic found, prev;
    int   high, low;

    // Reset
    repeat (3) @(negedge clk);
    check_val("reset_uo", uo_out, 8'h00);
    check_val("reset_uio", uio_out, 8'h00);
    check_val("reset_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic writes, reads and invalid addresses
    spi_send(32'h80F0, 16, "wr_en_out_lo");
    check_val("oe_const", uio_oe, 8'hFF);
    spi_send(32'h81CC, 16, "wr_en_out_hi");
    spi_send(32'h0100, 16, "read_ignored");
    spi_send(32'hB000, 16, "addr30_ignored");
    spi_send(32'h8500, 16, "addr05_zero");
    spi_send(32'h8001, 16, "en_out_lo_01");
    spi_send(32'h8100, 16, "en_out_hi_00");
    spi_send(32'h8201, 16, "en_pwm_lo_duty0");

    // PWM at 50% duty: measure high time and period
    spi_send(32'h8480, 16, "duty80");
    found = 1'b0;
    prev  = uo_out[0];
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      if (!prev && uo_out[0]) found = 1'b1;
      prev = uo_out[0];
    end
    check_val("pwm_rise_seen", found, 1'b1);
    high = 0;
    do begin
      @(negedge clk);
      high++;
    end while (uo_out[0] && high < 2 * PERIOD);
    low = 0;
    do begin
      @(negedge clk);
      low++;
    end while (!uo_out[0] && low < 2 * PERIOD);
    check_val("pwm_period_in_range", (high + low >= 3300) && (high + low <= 3370), 1'b1);
    check_val("pwm_high_in_range", (high >= 1631) && (high <= 1697), 1'b1);

    // Duty boundaries
    spi_send(32'h8400, 16, "duty00");
    hold_check(1'b0, "duty00_const0");
    spi_send(32'h84FF, 16, "dutyFF");
    hold_check(1'b1, "dutyFF_const1");
    spi_send(32'h8200, 16, "en_pwm_lo_00");

    // Short and long frames
    spi_send(32'h4007, 15, "short_frame_ignored");
    spi_send(32'h803CF, 20, "long_frame_first16");

    // Reset mid-frame
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h81, 8);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("midreset_uo", uo_out, 8'h00);
    check_val("midreset_uio", uio_out, 8'h00);
    check_val("midreset_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    check_val("aborted_no_commit", {uio_out, uo_out}, 16'h0000);
    spi_send(32'h80A5, 16, "after_abort_write");
    spi_send(32'h815A, 16, "after_abort_hi");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
